leaf_packet_injector: RTL and testbench
=======================================

// Module: leaf_packet_injector
// PURPOSE
//  Host-side transmitter for the leaf packet protocol. Turns host commands into BFT packets for one leaf interface:
//  port-0 config packets, port-1 RISC-V instruction-load packets ({addr[23:0],byte[7:0]}) and data-stream packets.
//  Sits between host/DMA logic and a BFT leaf port. Honours the BFT resend back-pressure.
// PARAMETERS
//  PACKET_BITS    49  total packet width; = 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+2+PAYLOAD_BITS
//  PAYLOAD_BITS   32  payload field width
//  NUM_LEAF_BITS  3   destination leaf field width
//  NUM_PORT_BITS  4   destination port field width
//  NUM_ADDR_BITS  7   packet addr/sequence field width
//  LEN_BITS       16  command length field width
// PORTS
//  clk          in   1              clock
//  reset        in   1              asynchronous, active-low reset (0 = reset)
//  cmd_vld      in   1              command valid
//  cmd_rdy      out  1              command accepted when cmd_vld & cmd_rdy
//  cmd_type     in   2              0=CFG 1=INSTR 2=STREAM 3=reserved
//  cmd_leaf     in   NUM_LEAF_BITS  destination leaf
//  cmd_port     in   NUM_PORT_BITS  destination port (STREAM only)
//  cmd_addr     in   NUM_ADDR_BITS  addr field (CFG only)
//  cmd_len      in   LEN_BITS       beats to send (INSTR/STREAM)
//  cmd_data     in   PAYLOAD_BITS   CFG payload / INSTR base address in [23:0]
//  din_vld      in   1              data beat valid
//  din_ack      out  1              data beat taken when din_vld & din_ack
//  din          in   PAYLOAD_BITS   data beat (INSTR uses din[7:0])
//  dout_host2bft out PACKET_BITS    registered packet to BFT
//  resend       in   1              BFT did not take last packet; hold
//  busy         out  1              FSM not IDLE
//  done         out  1              1-cycle pulse: command completed
//  cmd_err      out  1              1-cycle pulse: reserved cmd_type dropped
// BEHAVIOUR
//  Packet layout, MSB first: {vld, leaf, port, addr, 2'b00, payload}; idle/empty packet = all zeros.
//  Reset: all outputs 0, FSM IDLE, counters 0; asserted mid-command discards the remainder.
//  Resend: while resend=1 at a clock edge, dout, FSM and counters hold. cmd_rdy=0 and din_ack=0.
//  dout is re-written only when resend=0, including the write to zero after the last packet.
//  FSM IDLE: cmd_rdy = ~resend. On accept:
//   CFG                -> dout <= {1,leaf,0,cmd_addr,00,cmd_data} at t+1; done at t+1; stay IDLE.
//   INSTR/STREAM, len=0 -> no packet; done at t+1; stay IDLE.
//   INSTR/STREAM, len>0 -> latch leaf/port/base; rem <= len; seq <= 0; go INSTR/STREAM.
//   type 3             -> cmd_err at t+1; no packet; stay IDLE.
//   No accept          -> dout <= 0 (if resend=0).
//  INSTR/STREAM: din_ack = ~resend & (rem!=0), combinational.
//   Beat accepted at u -> packet on dout at u+1; full rate, 1 packet/cycle.
//   No beat            -> dout <= 0 (bubble).
//   INSTR packet: port=1, addr=seq, payload={iaddr[23:0],din[7:0]}; iaddr=base+seq, wraps mod 2^24.
//   STREAM packet: port=latched port, addr=seq mod 2^NUM_ADDR_BITS (wraps 127->0), payload=din.
//   Each beat: rem--, seq++. On last beat (rem==1): done and return to IDLE, both visible at u+1.
//   Next command is accepted no earlier than the cycle after that done.
//  done and cmd_err are registered; busy = (state!=IDLE).
// STRUCTURE
//  Header leaf_pkt_defines.vh holds:
//   - packet field offsets/widths
//   - reserved ports (CFG=0, INSTR=1)
//   - cmd_type codes and FSM state encodings
//  Sub-module leaf_pkt_pack: combinational field packer {vld,leaf,port,addr,pad,payload}.
//   Shared with future leaf-side decoders.
//  Top: FSM, rem/seq/iaddr counters, output register.
// TESTING
//  1 CFG leaf=5 addr=3 data=32'hDEADBEEF -> next cycle dout={1,3'd5,4'd0,7'd3,2'b0,32'hDEADBEEF}, done=1; then dout=0.
//  2 INSTR leaf=2 base=24'hFFFFFE len=3, bytes AA,BB,CC -> payloads FFFFFEAA,FFFFFFBB,000000CC; port=1, addr 0,1,2; done with last.
//  3 STREAM port=9 len=130, din back-to-back -> 130 consecutive packets; addr wraps 127->0; done on 130th; busy low after.
//  4 STREAM len=4, resend=1 for 2 cycles after 2nd packet -> 2nd packet held 2 extra cycles, din_ack=0 meanwhile.
//    Then 3rd and 4th follow, no loss or duplication.
//  5 din_vld gaps + len=0 cmd + type=3 cmd:
//    - gaps give zero bubbles on dout
//    - len=0 gives done, no packet
//    - type=3 gives cmd_err, no packet
//  6 reset low mid-STREAM (rem=5) -> dout=0, busy=0 immediately.
//    After release, a new CFG command is accepted and sent correctly.

Source files
------------

// File: rtl/leaf_packet_injector_pkg.sv
// ============================================================================
// Module : leaf_packet_injector_pkg
// Brief  : Packet field layout, reserved ports, command codes and FSM states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package leaf_packet_injector_pkg;

  localparam int DEF_PAYLOAD_BITS  = 32;
  localparam int DEF_NUM_LEAF_BITS = 3;
  localparam int DEF_NUM_PORT_BITS = 4;
  localparam int DEF_NUM_ADDR_BITS = 7;
  localparam int DEF_LEN_BITS      = 16;
  localparam int PAD_BITS          = 2;

  // Field offsets for the default geometry, LSB first.
  localparam int OFS_PAYLOAD = 0;
  localparam int OFS_PAD     = OFS_PAYLOAD + DEF_PAYLOAD_BITS;
  localparam int OFS_ADDR    = OFS_PAD + PAD_BITS;
  localparam int OFS_PORT    = OFS_ADDR + DEF_NUM_ADDR_BITS;
  localparam int OFS_LEAF    = OFS_PORT + DEF_NUM_PORT_BITS;
  localparam int OFS_VLD     = OFS_LEAF + DEF_NUM_LEAF_BITS;
  localparam int DEF_PACKET_BITS = OFS_VLD + 1;

  localparam int PORT_CFG   = 0;
  localparam int PORT_INSTR = 1;

  localparam int IADDR_BITS = 24;
  localparam int IBYTE_BITS = 8;

  typedef enum logic [1:0] {
    CMD_CFG    = 2'd0,
    CMD_INSTR  = 2'd1,
    CMD_STREAM = 2'd2,
    CMD_RSVD   = 2'd3
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INSTR  = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  function automatic int packet_bits(input int leaf_bits, input int port_bits,
                                     input int addr_bits, input int payload_bits);
    return 1 + leaf_bits + port_bits + addr_bits + PAD_BITS + payload_bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/leaf_packet_injector_if.sv
// ============================================================================
// Module : leaf_packet_injector_if
// Brief  : Host command/data handshake plus BFT packet port of the injector.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface leaf_packet_injector_if #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 3,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int LEN_BITS      = 16
) ();

  logic                     cmd_vld;
  logic                     cmd_rdy;
  logic [1:0]               cmd_type;
  logic [NUM_LEAF_BITS-1:0] cmd_leaf;
  logic [NUM_PORT_BITS-1:0] cmd_port;
  logic [NUM_ADDR_BITS-1:0] cmd_addr;
  logic [LEN_BITS-1:0]      cmd_len;
  logic [PAYLOAD_BITS-1:0]  cmd_data;
  logic                     din_vld;
  logic                     din_ack;
  logic [PAYLOAD_BITS-1:0]  din;
  logic [PACKET_BITS-1:0]   dout_host2bft;
  logic                     resend;
  logic                     busy;
  logic                     done;
  logic                     cmd_err;

  modport master (
    output cmd_vld, cmd_type, cmd_leaf, cmd_port, cmd_addr, cmd_len, cmd_data,
    output din_vld, din, resend,
    input  cmd_rdy, din_ack, dout_host2bft, busy, done, cmd_err
  );

  modport slave (
    input  cmd_vld, cmd_type, cmd_leaf, cmd_port, cmd_addr, cmd_len, cmd_data,
    input  din_vld, din, resend,
    output cmd_rdy, din_ack, dout_host2bft, busy, done, cmd_err
  );

endinterface

`default_nettype wire

// File: rtl/leaf_packet_injector_pack.sv
// ============================================================================
// Module : leaf_pkt_pack
// Brief  : Combinational packer {vld, leaf, port, addr, pad, payload}.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module leaf_pkt_pack #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 3,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7
) (
  input  logic                     vld,
  input  logic [NUM_LEAF_BITS-1:0] leaf,
  input  logic [NUM_PORT_BITS-1:0] port,
  input  logic [NUM_ADDR_BITS-1:0] addr,
  input  logic [PAYLOAD_BITS-1:0]  payload,
  output logic [PACKET_BITS-1:0]   packet
);

  assign packet = {vld, leaf, port, addr, 2'b00, payload};

endmodule

`default_nettype wire

// File: rtl/leaf_packet_injector.sv
// ============================================================================
// Module : leaf_packet_injector
// Brief  : Turns host commands into CFG/INSTR/STREAM BFT packets for one leaf.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module leaf_packet_injector
  import leaf_packet_injector_pkg::*;
#(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 3,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int LEN_BITS      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  leaf_packet_injector_if.slave bus
);

  state_e                   state_q, state_d;
  logic [LEN_BITS-1:0]      rem_q, rem_d;
  logic [NUM_ADDR_BITS-1:0] seq_q, seq_d;
  logic [IADDR_BITS-1:0]    iaddr_q, iaddr_d;
  logic [NUM_LEAF_BITS-1:0] leaf_q, leaf_d;
  logic [NUM_PORT_BITS-1:0] port_q, port_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic                     done_q, done_d;
  logic                     cmd_err_q, cmd_err_d;

  logic                     busy_w;
  logic                     cmd_rdy_w;
  logic                     din_ack_w;
  logic                     cmd_fire_w;
  logic                     beat_fire_w;
  cmd_type_e                cmd_type_w;

  logic [NUM_LEAF_BITS-1:0] pk_leaf_w;
  logic [NUM_PORT_BITS-1:0] pk_port_w;
  logic [NUM_ADDR_BITS-1:0] pk_addr_w;
  logic [PAYLOAD_BITS-1:0]  pk_payload_w;
  logic [PACKET_BITS-1:0]   pk_packet_w;

  assign cmd_type_w  = cmd_type_e'(bus.cmd_type);
  assign busy_w      = (state_q != ST_IDLE);
  assign cmd_rdy_w   = (state_q == ST_IDLE) & ~bus.resend;
  assign din_ack_w   = busy_w & ~bus.resend & (rem_q != '0);
  assign cmd_fire_w  = bus.cmd_vld & cmd_rdy_w;
  assign beat_fire_w = bus.din_vld & din_ack_w;

  // In IDLE the packer is fed straight from the command (CFG); otherwise from latched fields.
  always_comb begin
    pk_leaf_w    = bus.cmd_leaf;
    pk_port_w    = NUM_PORT_BITS'(PORT_CFG);
    pk_addr_w    = bus.cmd_addr;
    pk_payload_w = bus.cmd_data;
    case (state_q)
      ST_INSTR: begin
        pk_leaf_w    = leaf_q;
        pk_port_w    = NUM_PORT_BITS'(PORT_INSTR);
        pk_addr_w    = seq_q;
        pk_payload_w = PAYLOAD_BITS'({iaddr_q, bus.din[IBYTE_BITS-1:0]});
      end
      ST_STREAM: begin
        pk_leaf_w    = leaf_q;
        pk_port_w    = port_q;
        pk_addr_w    = seq_q;
        pk_payload_w = bus.din;
      end
      default: ;
    endcase
  end

  leaf_pkt_pack #(
    .PACKET_BITS   (PACKET_BITS),
    .PAYLOAD_BITS  (PAYLOAD_BITS),
    .NUM_LEAF_BITS (NUM_LEAF_BITS),
    .NUM_PORT_BITS (NUM_PORT_BITS),
    .NUM_ADDR_BITS (NUM_ADDR_BITS)
  ) u_pack (
    .vld     (1'b1),
    .leaf    (pk_leaf_w),
    .port    (pk_port_w),
    .addr    (pk_addr_w),
    .payload (pk_payload_w),
    .packet  (pk_packet_w)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    seq_d     = seq_q;
    iaddr_d   = iaddr_q;
    leaf_d    = leaf_q;
    port_d    = port_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
    cmd_err_d = 1'b0;
    // Under resend every piece of state, including dout, is frozen.
    if (!bus.resend) begin
      dout_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_fire_w) begin
            case (cmd_type_w)
              CMD_CFG: begin
                dout_d = pk_packet_w;
                done_d = 1'b1;
              end
              CMD_INSTR, CMD_STREAM: begin
                if (bus.cmd_len == '0) begin
                  done_d = 1'b1;
                end else begin
                  leaf_d  = bus.cmd_leaf;
                  port_d  = bus.cmd_port;
                  iaddr_d = bus.cmd_data[IADDR_BITS-1:0];
                  rem_d   = bus.cmd_len;
                  seq_d   = '0;
                  state_d = (cmd_type_w == CMD_INSTR) ? ST_INSTR : ST_STREAM;
                end
              end
              default: cmd_err_d = 1'b1;
            endcase
          end
        end
        ST_INSTR, ST_STREAM: begin
          if (beat_fire_w) begin
            dout_d  = pk_packet_w;
            rem_d   = rem_q - LEN_BITS'(1);
            seq_d   = seq_q + NUM_ADDR_BITS'(1);
            iaddr_d = iaddr_q + IADDR_BITS'(1);
            if (rem_q == LEN_BITS'(1)) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      seq_q     <= '0;
      iaddr_q   <= '0;
      leaf_q    <= '0;
      port_q    <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      seq_q     <= seq_d;
      iaddr_q   <= iaddr_d;
      leaf_q    <= leaf_d;
      port_q    <= port_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign bus.cmd_rdy       = cmd_rdy_w;
  assign bus.din_ack       = din_ack_w;
  assign bus.dout_host2bft = dout_q;
  assign bus.busy          = busy_w;
  assign bus.done          = done_q;
  assign bus.cmd_err       = cmd_err_q;

endmodule

`default_nettype wire

// File: tb/tb_leaf_packet_injector.sv
// ============================================================================
// Module : tb_leaf_packet_injector
// Brief  : Directed self-checking bench for leaf_packet_injector.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_leaf_packet_injector;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  leaf_packet_injector_if bus ();

  leaf_packet_injector dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [48:0] pkt(input logic [2:0] leaf, input logic [3:0] port,
                                      input logic [6:0] addr, input logic [31:0] pl);
    return {1'b1, leaf, port, addr, 2'b00, pl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.cmd_vld  = 1'b0;
    bus.cmd_type = 2'd0;
    bus.cmd_leaf = '0;
    bus.cmd_port = '0;
    bus.cmd_addr = '0;
    bus.cmd_len  = '0;
    bus.cmd_data = '0;
    bus.din_vld  = 1'b0;
    bus.din      = '0;
    bus.resend   = 1'b0;
  endtask

  // Presents one command for exactly one cycle (DUT must be ready).
  task automatic send_cmd(input logic [1:0] t, input logic [2:0] leaf, input logic [3:0] port,
                          input logic [6:0] addr, input logic [15:0] len, input logic [31:0] data);
    bus.cmd_vld  = 1'b1;
    bus.cmd_type = t;
    bus.cmd_leaf = leaf;
    bus.cmd_port = port;
    bus.cmd_addr = addr;
    bus.cmd_len  = len;
    bus.cmd_data = data;
    tick();
    bus.cmd_vld  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    tick();
    tick();
    n_checks++; if (bus.dout_host2bft !== 49'd0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", bus.dout_host2bft); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.cmd_err !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_err: got %b expected 0", bus.cmd_err); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_cfg();
    bus.cmd_vld = 1'b1; bus.cmd_type = 2'd0; bus.cmd_leaf = 3'd5; bus.cmd_addr = 7'd3;
    bus.cmd_data = 32'hDEADBEEF;
    #1;
    n_checks++; if (bus.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL cfg_rdy: got %b expected 1", bus.cmd_rdy); end
    tick();
    bus.cmd_vld = 1'b0;
    n_checks++; if (bus.dout_host2bft !== pkt(3'd5, 4'd0, 7'd3, 32'hDEADBEEF)) begin n_fail++; $display("FAIL cfg_pkt: got %h expected %h", bus.dout_host2bft, pkt(3'd5, 4'd0, 7'd3, 32'hDEADBEEF)); end
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL cfg_done: got %b expected 1", bus.done); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL cfg_busy: got %b expected 0", bus.busy); end
    tick();
    n_checks++; if (bus.dout_host2bft !== 49'd0) begin n_fail++; $display("FAIL cfg_clear: got %h expected 0", bus.dout_host2bft); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL cfg_done_pulse: got %b expected 0", bus.done); end
  endtask

  task automatic test_instr();
    logic [7:0]  bytes [3];
    logic [31:0] exp_pl [3];
    bytes  = '{8'hAA, 8'hBB, 8'hCC};
    exp_pl = '{32'hFFFFFEAA, 32'hFFFFFFBB, 32'h000000CC};
    send_cmd(2'd1, 3'd2, 4'd0, 7'd0, 16'd3, 32'h00FFFFFE);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL instr_busy: got %b expected 1", bus.busy); end
    n_checks++; if (bus.dout_host2bft !== 49'd0) begin n_fail++; $display("FAIL instr_nopkt: got %h expected 0", bus.dout_host2bft); end
    for (int i = 0; i < 3; i++) begin
      bus.din_vld = 1'b1;
      bus.din     = {24'h5A5A5A, bytes[i]};
      #1;
      n_checks++; if (bus.din_ack !== 1'b1) begin n_fail++; $display("FAIL instr_ack%0d: got %b expected 1", i, bus.din_ack); end
      tick();
      n_checks++; if (bus.dout_host2bft !== pkt(3'd2, 4'd1, 7'(i), exp_pl[i])) begin n_fail++; $display("FAIL instr_pkt%0d: got %h expected %h", i, bus.dout_host2bft, pkt(3'd2, 4'd1, 7'(i), exp_pl[i])); end
      n_checks++; if (bus.done !== (i == 2)) begin n_fail++; $display("FAIL instr_done%0d: got %b expected %b", i, bus.done, (i == 2)); end
    end
    bus.din_vld = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL instr_idle: got %b expected 0", bus.busy); end
    tick();
    n_checks++; if (bus.dout_host2bft !== 49'd0) begin n_fail++; $display("FAIL instr_clear: got %h expected 0", bus.dout_host2bft); end
  endtask

  task automatic test_back_to_back();
    send_cmd(2'd2, 3'd4, 4'd9, 7'd0, 16'd130, 32'h0);
    for (int i = 0; i < 130; i++) begin
      bus.din_vld = 1'b1;
      bus.din     = 32'hA5000000 | i;
      tick();
      n_checks++; if (bus.dout_host2bft !== pkt(3'd4, 4'd9, 7'(i), 32'hA5000000 | i)) begin n_fail++; $display("FAIL stream_pkt%0d: got %h expected %h", i, bus.dout_host2bft, pkt(3'd4, 4'd9, 7'(i), 32'hA5000000 | i)); end
      n_checks++; if (bus.done !== (i == 129)) begin n_fail++; $display("FAIL stream_done%0d: got %b expected %b", i, bus.done, (i == 129)); end
    end
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stream_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.din_ack !== 1'b0) begin n_fail++; $display("FAIL stream_ack_after: got %b expected 0", bus.din_ack); end
    bus.din_vld = 1'b0;
    tick();
    n_checks++; if (bus.dout_host2bft !== 49'd0) begin n_fail++; $display("FAIL stream_clear: got %h expected 0", bus.dout_host2bft); end
  endtask

  task automatic test_resend();
    send_cmd(2'd2, 3'd1, 4'd3, 7'd0, 16'd4, 32'h0);
    bus.din_vld = 1'b1;
    bus.din = 32'h00000010; tick();
    bus.din = 32'h00000011; tick();
    n_checks++; if (bus.dout_host2bft !== pkt(3'd1, 4'd3, 7'd1, 32'h11)) begin n_fail++; $display("FAIL rs_pkt1: got %h expected %h", bus.dout_host2bft, pkt(3'd1, 4'd3, 7'd1, 32'h11)); end
    bus.din = 32'h00000012;
    bus.resend = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++; if (bus.din_ack !== 1'b0) begin n_fail++; $display("FAIL rs_ack%0d: got %b expected 0", k, bus.din_ack); end
      tick();
      n_checks++; if (bus.dout_host2bft !== pkt(3'd1, 4'd3, 7'd1, 32'h11)) begin n_fail++; $display("FAIL rs_hold%0d: got %h expected %h", k, bus.dout_host2bft, pkt(3'd1, 4'd3, 7'd1, 32'h11)); end
    end
    bus.resend = 1'b0;
    #1;
    n_checks++; if (bus.din_ack !== 1'b1) begin n_fail++; $display("FAIL rs_ack_resume: got %b expected 1", bus.din_ack); end
    tick();
    n_checks++; if (bus.dout_host2bft !== pkt(3'd1, 4'd3, 7'd2, 32'h12)) begin n_fail++; $display("FAIL rs_pkt2: got %h expected %h", bus.dout_host2bft, pkt(3'd1, 4'd3, 7'd2, 32'h12)); end
    bus.din = 32'h00000013; tick();
    n_checks++; if (bus.dout_host2bft !== pkt(3'd1, 4'd3, 7'd3, 32'h13)) begin n_fail++; $display("FAIL rs_pkt3: got %h expected %h", bus.dout_host2bft, pkt(3'd1, 4'd3, 7'd3, 32'h13)); end
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL rs_done: got %b expected 1", bus.done); end
    bus.din_vld = 1'b0;
    tick();
    n_checks++; if (bus.dout_host2bft !== 49'd0) begin n_fail++; $display("FAIL rs_clear: got %h expected 0", bus.dout_host2bft); end
  endtask

  task automatic test_gaps_len0_rsvd();
    send_cmd(2'd2, 3'd0, 4'd2, 7'd0, 16'd2, 32'h0);
    tick();
    n_checks++; if (bus.dout_host2bft !== 49'd0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL gap_bubble0: got dout=%h busy=%b expected 0/1", bus.dout_host2bft, bus.busy); end
    bus.din_vld = 1'b1; bus.din = 32'hCAFE0001; tick();
    n_checks++; if (bus.dout_host2bft !== pkt(3'd0, 4'd2, 7'd0, 32'hCAFE0001)) begin n_fail++; $display("FAIL gap_pkt0: got %h expected %h", bus.dout_host2bft, pkt(3'd0, 4'd2, 7'd0, 32'hCAFE0001)); end
    bus.din_vld = 1'b0; tick();
    n_checks++; if (bus.dout_host2bft !== 49'd0) begin n_fail++; $display("FAIL gap_bubble1: got %h expected 0", bus.dout_host2bft); end
    bus.din_vld = 1'b1; bus.din = 32'hCAFE0002; tick();
    n_checks++; if (bus.dout_host2bft !== pkt(3'd0, 4'd2, 7'd1, 32'hCAFE0002) || bus.done !== 1'b1) begin n_fail++; $display("FAIL gap_pkt1: got %h done=%b expected %h done=1", bus.dout_host2bft, bus.done, pkt(3'd0, 4'd2, 7'd1, 32'hCAFE0002)); end
    bus.din_vld = 1'b0;
    send_cmd(2'd1, 3'd6, 4'd0, 7'd0, 16'd0, 32'h123456);
    n_checks++; if (bus.done !== 1'b1 || bus.dout_host2bft !== 49'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL len0: got done=%b dout=%h busy=%b expected 1/0/0", bus.done, bus.dout_host2bft, bus.busy); end
    send_cmd(2'd3, 3'd6, 4'd5, 7'd9, 16'd4, 32'h1);
    n_checks++; if (bus.cmd_err !== 1'b1 || bus.done !== 1'b0 || bus.dout_host2bft !== 49'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rsvd: got err=%b done=%b dout=%h busy=%b expected 1/0/0/0", bus.cmd_err, bus.done, bus.dout_host2bft, bus.busy); end
    tick();
    n_checks++; if (bus.cmd_err !== 1'b0) begin n_fail++; $display("FAIL rsvd_pulse: got %b expected 0", bus.cmd_err); end
  endtask

  task automatic test_reset_mid();
    send_cmd(2'd2, 3'd3, 4'd7, 7'd0, 16'd10, 32'h0);
    bus.din_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.din = 32'h77000000 | i;
      tick();
    end
    n_checks++; if (bus.dout_host2bft !== pkt(3'd3, 4'd7, 7'd4, 32'h77000004)) begin n_fail++; $display("FAIL rm_pkt4: got %h expected %h", bus.dout_host2bft, pkt(3'd3, 4'd7, 7'd4, 32'h77000004)); end
    reset = 1'b0;
    #1;
    n_checks++; if (bus.dout_host2bft !== 49'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rm_async: got dout=%h busy=%b expected 0/0", bus.dout_host2bft, bus.busy); end
    tick();
    reset = 1'b1;
    bus.din_vld = 1'b0;
    tick();
    n_checks++; if (bus.dout_host2bft !== 49'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rm_after: got dout=%h busy=%b expected 0/0", bus.dout_host2bft, bus.busy); end
    send_cmd(2'd0, 3'd7, 4'd0, 7'h7F, 16'd0, 32'h12345678);
    n_checks++; if (bus.dout_host2bft !== pkt(3'd7, 4'd0, 7'h7F, 32'h12345678) || bus.done !== 1'b1) begin n_fail++; $display("FAIL rm_cfg: got %h done=%b expected %h done=1", bus.dout_host2bft, bus.done, pkt(3'd7, 4'd0, 7'h7F, 32'h12345678)); end
  endtask

  initial begin
    test_reset();
    test_cfg();
    test_instr();
    test_back_to_back();
    test_resend();
    test_gaps_len0_rsvd();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
